ecc_scrubber: RTL and testbench
===============================

ECC_SCRUBBER -- requirements
Module: ecc_scrubber

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 14, memory word-address width.
REQ-002 The block SHALL have parameter CNT_W, default 16, error-counter width.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 NSYSRESET  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a scan; honoured only in IDLE.
REQ-006 stop  input  1  level; when high, the scan ends after the word in progress.
REQ-007 scrub_base  input  ADDR_W  first address of the scan; sampled on an accepted start.
REQ-008 scrub_last  input  ADDR_W  last address of the scan; sampled on an accepted start.
REQ-009 R_EN  output  1  memory read strobe.
REQ-010 R_ADDR  output  ADDR_W  memory read address.
REQ-011 R_DATA  input  72  codeword returned one cycle after the R_EN cycle.
REQ-012 W_EN  output  1  memory write strobe.
REQ-013 W_ADDR  output  ADDR_W  memory write address.
REQ-014 W_DATA  output  72  corrected codeword.
REQ-015 busy  output  1  high from an accepted start until done.
REQ-016 done  output  1  one-cycle pulse at the end of a scan.
REQ-017 SGLl  output  1  one-cycle pulse when a single-bit error is corrected.
REQ-018 DBLl  output  1  one-cycle pulse when an uncorrectable error is detected.
REQ-019 err_addr  output  ADDR_W  address of the most recent SGLl or DBLl event.
REQ-020 sgl_cnt  output  CNT_W  count of single-bit errors in the current or last scan.
REQ-021 dbl_cnt  output  CNT_W  count of uncorrectable errors in the current or last scan.

Function
REQ-022 Codeword layout SHALL be as follows.
- cw[0] is overall even parity over cw[71:1].
- cw[1], cw[2], cw[4], cw[8], cw[16], cw[32], cw[64] are Hamming check bits.
- data[63:0] occupy the remaining positions 3..71 in ascending order, data[0] at cw[3].
REQ-023 Syndrome S[6:0] SHALL be the XOR of indices i in 1..71 where cw[i]=1; P SHALL be the XOR of cw[71:0].
REQ-024 Classification SHALL be as follows.
- S=0 and P=0: clean.
- P=1 and S<=71: single error at position S, where S=0 means cw[0].
- Any other combination: uncorrectable.
REQ-025 The FSM SHALL have states IDLE, RD, WT, CK, WB and FIN.
REQ-026 IDLE->RD SHALL occur on start; entry clears sgl_cnt and dbl_cnt and loads addr=scrub_base.
REQ-027 RD SHALL assert R_EN=1 with R_ADDR=addr for exactly one cycle, then go to WT.
REQ-028 WT SHALL register R_DATA, then go to CK.
REQ-029 CK SHALL decode the registered word and act on the classification.
- clean: go to next-step.
- single: pulse SGLl, set err_addr=addr, go to WB.
- uncorrectable: pulse DBLl, set err_addr=addr, increment dbl_cnt, go to next-step; no write.
REQ-030 WB SHALL assert W_EN=1 for one cycle with W_ADDR=addr and W_DATA equal to the word with bit S inverted, and SHALL increment sgl_cnt.
REQ-031 Next-step SHALL go to FIN if addr==scrub_last or stop=1; otherwise addr=addr+1 modulo 2^ADDR_W and go to RD.
REQ-032 Latency SHALL be 3 cycles per clean or uncorrectable word and 4 cycles per corrected word.
REQ-033 FIN SHALL pulse done for one cycle, drop busy and return to IDLE.
REQ-034 If scrub_last < scrub_base, the scan SHALL wrap through the address maximum to 0.
REQ-035 If scrub_base == scrub_last, the scan SHALL cover exactly one word.
REQ-036 A start that arrives while busy SHALL be ignored.
REQ-037 Counters SHALL saturate at all-ones and hold their value after done until the next accepted start.
REQ-038 R_EN and W_EN SHALL never be high in the same cycle.

Reset
REQ-039 While NSYSRESET=0, the block SHALL force state=IDLE and all outputs to 0, including counters and err_addr, regardless of any scan in progress.
REQ-040 A reset during WB SHALL abort the write immediately; no W_EN pulse SHALL follow the release of reset.

Verification
REQ-041 Clean scan: memory[1..3] holds encodings of 10, 20, 30; start with base=1, last=3 -> 3 R_EN pulses, no W_EN, done at cycle 10 after start, both counters 0.
REQ-042 Single-bit error: memory[2] holds the encoding of 20 with cw[5] flipped -> SGLl once, err_addr=2, W_EN once with W_ADDR=2 and W_DATA equal to the clean encoding of 20, sgl_cnt=1.
REQ-043 Double-bit error: memory[3] holds the encoding of 30 with cw[5] and cw[9] flipped -> DBLl once, err_addr=3, no write, dbl_cnt=1, scan continues to done.
REQ-044 Wrap and stop: base=16382, last=1 -> reads at 16382, 16383, 0, 1 then done; a repeat run with stop raised during the second word -> done after that word.
REQ-045 Reset mid-scan: NSYSRESET low during WB -> busy, W_EN and counters read 0 immediately; a new start afterwards runs normally.
REQ-046 Parity-bit-only error: cw[0] flipped -> classified single with S=0, write-back restores cw[0], sgl_cnt increments.

Source files
------------

// File: rtl/ecc_scrubber.sv
// Background ECC scrubber for a (72,64) SEC-DED memory: reads each word in a
// range, corrects single-bit errors by write-back and counts uncorrectable ones.
module ecc_scrubber #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              NSYSRESET,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] scrub_base,
  input  logic [ADDR_W-1:0] scrub_last,
  output logic              R_EN,
  output logic [ADDR_W-1:0] R_ADDR,
  input  logic [71:0]       R_DATA,
  output logic              W_EN,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [71:0]       W_DATA,
  output logic              busy,
  output logic              done,
  output logic              SGLl,
  output logic              DBLl,
  output logic [ADDR_W-1:0] err_addr,
  output logic [CNT_W-1:0]  sgl_cnt,
  output logic [CNT_W-1:0]  dbl_cnt
);

  localparam int unsigned CW_W  = 72;
  localparam int unsigned SYN_W = 7;

  typedef enum logic [2:0] {IDLE, RD, WT, CK, WB, FIN} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q, last_q;
  logic [CW_W-1:0]   word_q;
  logic              r_en_q, w_en_q, busy_q, done_q, sgl_q, dbl_q;
  logic [ADDR_W-1:0] r_addr_q, w_addr_q, err_addr_q;
  logic [CW_W-1:0]   w_data_q;
  logic [CNT_W-1:0]  sgl_cnt_q, dbl_cnt_q;

  logic [SYN_W-1:0]  syn_c;
  logic              par_c, clean_c, fixable_c, end_c;
  logic [CW_W-1:0]   fixed_c;
  logic [ADDR_W-1:0] addr_inc_c;
  logic [CNT_W-1:0]  sgl_inc_c, dbl_inc_c;

  // Syndrome/parity decode of the captured codeword plus next-step helpers
  always_comb begin
    syn_c = '0;
    for (int unsigned i = 1; i < CW_W; i++) begin
      if (word_q[i]) syn_c = syn_c ^ SYN_W'(i);
    end
    par_c      = ^word_q;
    clean_c    = (syn_c == '0) && !par_c;
    fixable_c  = par_c && (syn_c <= SYN_W'(CW_W - 1));
    fixed_c    = word_q ^ (CW_W'(1) << syn_c);
    end_c      = (addr_q == last_q) || stop;
    addr_inc_c = addr_q + ADDR_W'(1);
    sgl_inc_c  = (sgl_cnt_q == '1) ? sgl_cnt_q : sgl_cnt_q + CNT_W'(1);
    dbl_inc_c  = (dbl_cnt_q == '1) ? dbl_cnt_q : dbl_cnt_q + CNT_W'(1);
  end

  // Scan controller; all strobes default low so every pulse lasts one cycle
  always_ff @(posedge clk or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      last_q     <= '0;
      word_q     <= '0;
      r_en_q     <= 1'b0;
      r_addr_q   <= '0;
      w_en_q     <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sgl_q      <= 1'b0;
      dbl_q      <= 1'b0;
      err_addr_q <= '0;
      sgl_cnt_q  <= '0;
      dbl_cnt_q  <= '0;
    end else begin
      r_en_q <= 1'b0;
      w_en_q <= 1'b0;
      done_q <= 1'b0;
      sgl_q  <= 1'b0;
      dbl_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= RD;
            addr_q    <= scrub_base;
            last_q    <= scrub_last;
            r_en_q    <= 1'b1;
            r_addr_q  <= scrub_base;
            busy_q    <= 1'b1;
            sgl_cnt_q <= '0;
            dbl_cnt_q <= '0;
          end
        end
        RD: state_q <= WT;
        WT: begin
          word_q  <= R_DATA;
          state_q <= CK;
        end
        CK: begin
          if (fixable_c) begin
            state_q    <= WB;
            w_en_q     <= 1'b1;
            w_addr_q   <= addr_q;
            w_data_q   <= fixed_c;
            sgl_q      <= 1'b1;
            err_addr_q <= addr_q;
          end else begin
            if (!clean_c) begin
              dbl_q      <= 1'b1;
              err_addr_q <= addr_q;
              dbl_cnt_q  <= dbl_inc_c;
            end
            if (end_c) begin
              state_q <= FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q  <= RD;
              addr_q   <= addr_inc_c;
              r_en_q   <= 1'b1;
              r_addr_q <= addr_inc_c;
            end
          end
        end
        WB: begin
          sgl_cnt_q <= sgl_inc_c;
          if (end_c) begin
            state_q <= FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q  <= RD;
            addr_q   <= addr_inc_c;
            r_en_q   <= 1'b1;
            r_addr_q <= addr_inc_c;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign R_EN     = r_en_q;
  assign R_ADDR   = r_addr_q;
  assign W_EN     = w_en_q;
  assign W_ADDR   = w_addr_q;
  assign W_DATA   = w_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign SGLl     = sgl_q;
  assign DBLl     = dbl_q;
  assign err_addr = err_addr_q;
  assign sgl_cnt  = sgl_cnt_q;
  assign dbl_cnt  = dbl_cnt_q;

endmodule

// File: tb/tb_ecc_scrubber.sv
// Scoreboard bench for ecc_scrubber: a memory model, a word-level reference
// model that predicts reads/writes/events/latency, and a decoupled monitor.
module tb_ecc_scrubber;

  localparam int unsigned AW    = 14;
  localparam int unsigned CW    = 16;
  localparam int          DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          NSYSRESET = 1'b0;
  logic          start = 1'b0, stop = 1'b0;
  logic [AW-1:0] scrub_base = '0, scrub_last = '0;
  logic          R_EN, W_EN, busy, done, SGLl, DBLl;
  logic [AW-1:0] R_ADDR, W_ADDR, err_addr;
  logic [71:0]   R_DATA, W_DATA;
  logic [CW-1:0] sgl_cnt, dbl_cnt;

  int errors = 0;
  int checks = 0;

  logic [71:0]   mem [0:DEPTH-1];
  logic [71:0]   rdata = '0;
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_wa = '0;
  logic [71:0]   tb_wd = '0;

  int          exp_rd[$];
  int          exp_wa[$];
  logic [71:0] exp_wd[$];
  int          exp_ea[$];
  int          exp_et[$];
  int          exp_ds[$];
  int          exp_dd[$];

  ecc_scrubber #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .NSYSRESET(NSYSRESET), .start(start), .stop(stop),
    .scrub_base(scrub_base), .scrub_last(scrub_last),
    .R_EN(R_EN), .R_ADDR(R_ADDR), .R_DATA(R_DATA),
    .W_EN(W_EN), .W_ADDR(W_ADDR), .W_DATA(W_DATA),
    .busy(busy), .done(done), .SGLl(SGLl), .DBLl(DBLl),
    .err_addr(err_addr), .sgl_cnt(sgl_cnt), .dbl_cnt(dbl_cnt)
  );

  always #5 clk = ~clk;

  assign R_DATA = rdata;

  // Synchronous memory: read data valid the cycle after R_EN
  always @(posedge clk) begin
    if (R_EN) rdata <= mem[R_ADDR];
    if (W_EN) mem[W_ADDR] <= W_DATA;
    if (tb_we) mem[tb_wa] <= tb_wd;
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [71:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h expected no event", name, act);
  endtask

  function automatic logic [71:0] encode(input logic [63:0] d);
    logic [71:0] cw;
    int j;
    int p;
    logic b;
    cw = '0;
    j  = 0;
    for (int i = 3; i < 72; i++) begin
      if ((i & (i - 1)) != 0) begin
        cw[i] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 7; k++) begin
      p = 1 << k;
      b = 1'b0;
      for (int i = 1; i < 72; i++) if (i != p && (i & p) != 0) b ^= cw[i];
      cw[p] = b;
    end
    cw[0] = ^cw[71:1];
    return cw;
  endfunction

  task automatic mem_write(input int a, input logic [71:0] d);
    @(negedge clk);
    tb_we = 1'b1;
    tb_wa = AW'(a);
    tb_wd = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Reference model: walks the address range word by word, classifying each
  task automatic model(input int base, input int last, input int stop_after,
                       output int cyc, output int es, output int ed);
    int a, n, s;
    logic [71:0] w;
    logic p;
    a = base; n = 0; es = 0; ed = 0; cyc = 1;
    forever begin
      w = mem[a];
      exp_rd.push_back(a);
      n++;
      cyc += 3;
      s = 0;
      for (int i = 1; i < 72; i++) if (w[i]) s ^= i;
      p = ^w;
      if (!p && s == 0) begin
      end else if (p && s <= 71) begin
        exp_ea.push_back(a); exp_et.push_back(1);
        exp_wa.push_back(a);
        w[s] = ~w[s];
        exp_wd.push_back(w);
        if (es < (1 << CW) - 1) es++;
        cyc++;
      end else begin
        exp_ea.push_back(a); exp_et.push_back(2);
        if (ed < (1 << CW) - 1) ed++;
      end
      if (a == last || n == stop_after) break;
      a = (a + 1) % DEPTH;
    end
    exp_ds.push_back(es);
    exp_dd.push_back(ed);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event
  always @(negedge clk) begin
    if (NSYSRESET) begin
      if (R_EN && W_EN) fail("rw_overlap", 72'(W_ADDR));
      if (R_EN) begin
        if (exp_rd.size() == 0) fail("rd_unexpected", 72'(R_ADDR));
        else chk("rd_addr", 72'(R_ADDR), 72'(exp_rd.pop_front()));
      end
      if (W_EN) begin
        if (exp_wa.size() == 0) fail("wr_unexpected", 72'(W_ADDR));
        else begin
          chk("wr_addr", 72'(W_ADDR), 72'(exp_wa.pop_front()));
          chk("wr_data", W_DATA, exp_wd.pop_front());
        end
      end
      if (SGLl || DBLl) begin
        if (exp_et.size() == 0) fail("err_unexpected", 72'({DBLl, SGLl}));
        else begin
          chk("err_type", 72'({DBLl, SGLl}), 72'(exp_et.pop_front()));
          chk("err_addr", 72'(err_addr), 72'(exp_ea.pop_front()));
        end
      end
      if (done) begin
        if (exp_ds.size() == 0) fail("done_unexpected", 72'(done));
        else begin
          chk("done_sgl_cnt", 72'(sgl_cnt), 72'(exp_ds.pop_front()));
          chk("done_dbl_cnt", 72'(dbl_cnt), 72'(exp_dd.pop_front()));
          chk("done_busy", 72'(busy), 72'(0));
        end
      end
    end
  end

  task automatic flush();
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    exp_ea.delete(); exp_et.delete(); exp_ds.delete(); exp_dd.delete();
  endtask

  task automatic run_scan(input int base, input int last, input int stop_after, input bit poke);
    int exp_cyc, es, ed, cyc, nrd;
    bit seen;
    model(base, last, stop_after, exp_cyc, es, ed);
    @(negedge clk);
    scrub_base = AW'(base);
    scrub_last = AW'(last);
    start = 1'b1;
    @(posedge clk);
    cyc = 1; nrd = 0; seen = 1'b0;
    while (cyc < 300) begin
      @(negedge clk);
      start = 1'b0;
      if (R_EN) begin
        nrd++;
        if (nrd == stop_after) stop = 1'b1;
        if (poke && nrd == 2) begin
          start = 1'b1;
          scrub_base = AW'(base + 7);
        end
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    stop = 1'b0;
    start = 1'b0;
    chk("done_seen", 72'(seen), 72'(1));
    chk("latency", 72'(cyc), 72'(exp_cyc));
    repeat (2) @(negedge clk);
    chk("hold_sgl_cnt", 72'(sgl_cnt), 72'(es));
    chk("hold_dbl_cnt", 72'(dbl_cnt), 72'(ed));
    chk("idle_busy", 72'(busy), 72'(0));
    chk("rd_leftover", 72'(exp_rd.size() + exp_wa.size() + exp_et.size() + exp_ds.size()), 72'(0));
    flush();
  endtask

  initial begin
    int base, len, stop_after, r, b1, b2, b3, ec, es, ed;
    logic [71:0] w, bad;
    bit seen;

    repeat (3) @(negedge clk);
    chk("rst_outputs", {R_EN, W_EN, busy, done, SGLl, DBLl, R_ADDR, W_ADDR, err_addr, 2'b0},
        72'(0));
    chk("rst_counts", 72'({sgl_cnt, dbl_cnt}), 72'(0));
    chk("rst_wdata", W_DATA, 72'(0));
    NSYSRESET = 1'b1;

    // Clean scan, then single, double, parity-only errors
    mem_write(1, encode(64'd10)); mem_write(2, encode(64'd20)); mem_write(3, encode(64'd30));
    run_scan(1, 3, 0, 1'b0);
    w = encode(64'd20); w[5] = ~w[5];
    mem_write(2, w);
    run_scan(1, 3, 0, 1'b0);
    chk("mem2_fixed", mem[2], encode(64'd20));
    w = encode(64'd30); w[5] = ~w[5]; w[9] = ~w[9];
    mem_write(3, w);
    run_scan(1, 3, 0, 1'b0);
    chk("mem3_untouched", mem[3], w);
    w = encode(64'd10); w[0] = ~w[0];
    mem_write(1, w);
    run_scan(1, 3, 0, 1'b1);
    chk("mem1_parity_fixed", mem[1], encode(64'd10));

    // Wrap through the top of the address space, then the same with stop
    mem_write(16382, encode(64'd1)); mem_write(16383, encode(64'd2));
    mem_write(0, encode(64'd3)); mem_write(1, encode(64'd4));
    run_scan(16382, 1, 0, 1'b0);
    run_scan(16382, 1, 2, 1'b0);

    w = encode(64'hDEAD_BEEF_0123_4567); w[70] = ~w[70];
    mem_write(100, w);
    run_scan(100, 100, 0, 1'b0);

    // Reset asserted while the write-back strobe is high
    bad = encode(64'd77); bad[13] = ~bad[13];
    mem_write(40, bad); mem_write(41, encode(64'd78));
    model(40, 41, 0, ec, es, ed);
    @(negedge clk);
    scrub_base = AW'(40); scrub_last = AW'(41); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (W_EN) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("wb_reached", 72'(seen), 72'(1));
    #2 NSYSRESET = 1'b0;
    #1;
    chk("rst_mid_flags", 72'({busy, W_EN, R_EN, done, SGLl, DBLl}), 72'(0));
    chk("rst_mid_counts", 72'({sgl_cnt, dbl_cnt, err_addr}), 72'(0));
    flush();
    @(negedge clk);
    NSYSRESET = 1'b1;
    repeat (5) @(negedge clk);
    chk("wb_aborted", mem[40], bad);
    run_scan(40, 41, 0, 1'b0);

    // Randomized ranges and corruption patterns
    for (int it = 0; it < 25; it++) begin
      len  = $urandom_range(1, 6);
      base = (it % 5 == 0) ? DEPTH - int'($urandom_range(1, 3)) : int'($urandom_range(0, DEPTH - 1));
      for (int k = 0; k < len; k++) begin
        w  = encode({$urandom, $urandom});
        r  = $urandom_range(0, 9);
        b1 = $urandom_range(0, 71);
        b2 = (b1 + int'($urandom_range(1, 71))) % 72;
        do b3 = $urandom_range(0, 71); while (b3 == b1 || b3 == b2);
        if (r >= 5) w[b1] = ~w[b1];
        if (r >= 8) w[b2] = ~w[b2];
        if (r == 9) w[b3] = ~w[b3];
        mem_write((base + k) % DEPTH, w);
      end
      stop_after = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : 0;
      run_scan(base, (base + len - 1) % DEPTH, stop_after, len >= 3 && it % 4 == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
